// File: rtl/tape_boot_packer.sv
// Packs a host byte stream into 32-bit big-endian words for the tape RAM loader.
// Optional idle auto-flush is compiled in with `define TAPE_PACKER_TIMEOUT_EN.
`timescale 1ns/1ps
module tape_boot_packer #(
    parameter int          MAX_WORDS      = 4096,
    parameter logic [7:0]  PAD_BYTE       = 8'h80,
    parameter int          TIMEOUT_CYCLES = 5000000
) (
    input  logic        ram_clk,
    input  logic        reset,
    input  logic        file_start,
    input  logic        file_end,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [31:0] bootdata,
    output logic        bootdata_req,
    input  logic        bootdata_ack,
    output logic        busy,
    output logic        file_done,
    output logic [12:0] word_count,
    output logic        overflow
);

    typedef enum logic [1:0] {IDLE, FILL, FLUSH, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] bootdata_q, bootdata_d;
    logic        req_q, req_d;
    logic        file_done_q, file_done_d;
    logic        overflow_q, overflow_d;
    logic [12:0] word_count_q, word_count_d;
    logic [12:0] issued_q, issued_d;

    logic [31:0] packed_word;
    logic [31:0] pad_word;
    logic        accept;
    logic        full;
    logic        out_free;
    logic        ack_take;
    logic        end_evt;

    // packed_word: assembly with byte_in dropped into the current lane.
    // pad_word: assembly with the current lane and everything after it padded.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign packed_word[31-8*gi -: 8] = (lane_q == 2'(gi)) ? byte_in  : asm_q[31-8*gi -: 8];
            assign pad_word[31-8*gi -: 8]    = (2'(gi) >= lane_q) ? PAD_BYTE : asm_q[31-8*gi -: 8];
        end
    endgenerate

    assign ack_take   = req_q && bootdata_ack;
    assign out_free   = !req_q || bootdata_ack;
    assign byte_ready = (state_q == FILL) && !(lane_q == 2'd3 && req_q && !bootdata_ack);
    assign accept     = byte_valid && byte_ready;
    // issued counts every word loaded for output, so it covers acked plus in-flight words
    assign full       = issued_q >= 13'(MAX_WORDS);

`ifdef TAPE_PACKER_TIMEOUT_EN
    logic [22:0] idle_cnt_q, idle_cnt_d;
    logic        timeout;

    assign timeout = (state_q == FILL) && !accept && (idle_cnt_q >= 23'(TIMEOUT_CYCLES - 1));
    assign end_evt = file_end || timeout;

    always_comb begin
        idle_cnt_d = '0;
        if (state_q == FILL && !accept && !file_start) begin
            idle_cnt_d = idle_cnt_q + 23'd1;
        end
    end

    always_ff @(posedge ram_clk) begin
        if (reset) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign end_evt = file_end;
`endif

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        asm_d        = asm_q;
        bootdata_d   = bootdata_q;
        req_d        = req_q;
        word_count_d = word_count_q;
        issued_d     = issued_q;
        overflow_d   = overflow_q;
        file_done_d  = 1'b0;

        if (ack_take) begin
            req_d        = 1'b0;
            word_count_d = word_count_q + 13'd1;
        end

        case (state_q)
            IDLE: begin
            end
            FILL: begin
                if (accept) begin
                    if (full) begin
                        overflow_d = 1'b1;
                    end else if (lane_q == 2'd3) begin
                        asm_d      = packed_word;
                        bootdata_d = packed_word;
                        req_d      = 1'b1;
                        issued_d   = issued_q + 13'd1;
                        lane_d     = 2'd0;
                    end else begin
                        asm_d  = packed_word;
                        lane_d = lane_q + 2'd1;
                    end
                end
                if (end_evt) begin
                    state_d = (lane_d != 2'd0) ? FLUSH : DRAIN;
                end
            end
            FLUSH: begin
                if (overflow_q || full) begin
                    state_d = DRAIN;
                end else if (out_free) begin
                    bootdata_d = pad_word;
                    req_d      = 1'b1;
                    issued_d   = issued_q + 13'd1;
                    lane_d     = 2'd0;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                if (!req_q) begin
                    file_done_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new file aborts whatever is in progress, including a pending word
        if (file_start) begin
            state_d      = FILL;
            lane_d       = 2'd0;
            asm_d        = '0;
            req_d        = 1'b0;
            word_count_d = '0;
            issued_d     = '0;
            overflow_d   = 1'b0;
            file_done_d  = 1'b0;
        end
    end

    always_ff @(posedge ram_clk) begin
        if (reset) begin
            state_q      <= IDLE;
            lane_q       <= 2'd0;
            asm_q        <= '0;
            bootdata_q   <= '0;
            req_q        <= 1'b0;
            word_count_q <= '0;
            issued_q     <= '0;
            overflow_q   <= 1'b0;
            file_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            asm_q        <= asm_d;
            bootdata_q   <= bootdata_d;
            req_q        <= req_d;
            word_count_q <= word_count_d;
            issued_q     <= issued_d;
            overflow_q   <= overflow_d;
            file_done_q  <= file_done_d;
        end
    end

    assign bootdata     = bootdata_q;
    assign bootdata_req = req_q;
    assign busy         = (state_q != IDLE);
    assign file_done    = file_done_q;
    assign word_count   = word_count_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_tape_boot_packer.sv
// Scoreboard bench for tape_boot_packer: directed files, loader-style ack model, word queue check.
`timescale 1ns/1ps
module tb_tape_boot_packer;

    localparam int MAXW = 4;

    logic        ram_clk = 1'b0;
    logic        reset;
    logic        file_start;
    logic        file_end;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [31:0] bootdata;
    logic        bootdata_req;
    logic        bootdata_ack;
    logic        busy;
    logic        file_done;
    logic [12:0] word_count;
    logic        overflow;

    int          vectors = 0;
    int          errors  = 0;
    logic [31:0] exp_q[$];
    int          acks_seen = 0;
    int          cyc = 0;
    int          cyc_req_fall = 0;
    int          cyc_done = 0;

    bit          ack_hold = 1'b0;
    bit          ack_spur = 1'b0;
    int          ack_delay = 0;
    bit          ramwait = 1'b0;
    int          wait_cnt = 0;

    logic        req_prev = 1'b0;
    logic        ack_prev = 1'b0;
    logic [31:0] data_prev = '0;

    tape_boot_packer #(
        .MAX_WORDS(MAXW),
        .PAD_BYTE(8'h80),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .ram_clk(ram_clk),
        .reset(reset),
        .file_start(file_start),
        .file_end(file_end),
        .byte_in(byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .bootdata(bootdata),
        .bootdata_req(bootdata_req),
        .bootdata_ack(bootdata_ack),
        .busy(busy),
        .file_done(file_done),
        .word_count(word_count),
        .overflow(overflow)
    );

    always #10 ram_clk = ~ram_clk;

    always @(posedge ram_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    // Loader model: ack a pending word after ack_delay cycles, then one ramwait cycle.
    initial begin
        bootdata_ack = 1'b0;
        forever begin
            @(posedge ram_clk);
            #1;
            if (bootdata_ack) begin
                bootdata_ack = 1'b0;
                ramwait = 1'b1;
            end else if (ramwait) begin
                ramwait = 1'b0;
            end else if (ack_spur && !bootdata_req) begin
                bootdata_ack = 1'b1;
            end else if (bootdata_req && !ack_hold) begin
                if (wait_cnt >= ack_delay) begin
                    bootdata_ack = 1'b1;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on each handshake, watches data stability.
    initial begin
        forever begin
            @(negedge ram_clk);
            if (!reset) begin
                if (req_prev && !ack_prev && bootdata_req)
                    check("bootdata_stable", bootdata, data_prev);
                if (req_prev && !bootdata_req)
                    cyc_req_fall = cyc;
                if (bootdata_req && bootdata_ack) begin
                    acks_seen++;
                    if (exp_q.size() == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL unexpected_word: got %h, required no word", bootdata);
                    end else begin
                        check("word", bootdata, exp_q.pop_front());
                    end
                end
                if (file_done)
                    cyc_done = cyc;
            end
            req_prev  = bootdata_req;
            ack_prev  = bootdata_ack;
            data_prev = bootdata;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge ram_clk);
        #1;
    endtask

    task automatic start_file();
        file_start = 1'b1;
        tick();
        file_start = 1'b0;
    endtask

    task automatic end_file();
        file_end = 1'b1;
        tick();
        file_end = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit with_end);
        int n;
        n = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        forever begin
            @(negedge ram_clk);
            if (byte_ready) break;
            n++;
            if (n > 200) begin
                vectors++;
                errors++;
                $display("FAIL byte_accept_timeout: byte %h not accepted, required accept within 200 cycles", b);
                break;
            end
        end
        file_end = with_end;
        tick();
        byte_valid = 1'b0;
        file_end   = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (n < limit && file_done !== 1'b1) begin
            @(negedge ram_clk);
            n++;
        end
        check("file_done_seen", {31'b0, file_done}, 32'd1);
        tick();
    endtask

    initial begin
        reset = 1'b1; file_start = 1'b0; file_end = 1'b0;
        byte_in = 8'h00; byte_valid = 1'b0;
        repeat (3) @(posedge ram_clk);
        #1 reset = 1'b0;
        @(negedge ram_clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_req", {31'b0, bootdata_req}, 32'd0);
        check("rst_ready", {31'b0, byte_ready}, 32'd0);
        check("rst_bootdata", bootdata, 32'd0);
        check("rst_word_count", {19'b0, word_count}, 32'd0);
        check("rst_overflow", {31'b0, overflow}, 32'd0);
        check("rst_file_done", {31'b0, file_done}, 32'd0);
        tick();

        // Basic pack, ack two cycles after each req
        ack_delay = 2;
        exp_q.push_back(32'h01020304);
        exp_q.push_back(32'h05060708);
        start_file();
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
        end_file();
        wait_done(60);
        check("basic_word_count", {19'b0, word_count}, 32'd2);
        check("basic_done_latency", 32'(cyc_done - cyc_req_fall), 32'd1);
        check("basic_busy_after", {31'b0, busy}, 32'd0);

        // Spurious ack ignored, then partial word
        ack_delay = 0;
        start_file();
        ack_spur = 1'b1;
        repeat (4) tick();
        ack_spur = 1'b0;
        repeat (2) tick();
        check("spurious_ack_ignored", {19'b0, word_count}, 32'd0);
        exp_q.push_back(32'hAABB8080);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        end_file();
        wait_done(60);
        check("partial_word_count", {19'b0, word_count}, 32'd1);

        // file_end on the same cycle as the last byte (lane 2 -> pad one lane)
        exp_q.push_back(32'hC1C2C3C4);
        exp_q.push_back(32'hC5C6C780);
        start_file();
        for (int i = 1; i <= 6; i++) send_byte(8'hC0 + 8'(i), 1'b0);
        send_byte(8'hC7, 1'b1);
        wait_done(60);
        check("end_with_byte_count", {19'b0, word_count}, 32'd2);

        // file_end with a lane-3 byte: no padded word follows
        exp_q.push_back(32'hD1D2D3D4);
        start_file();
        for (int i = 1; i <= 3; i++) send_byte(8'hD0 + 8'(i), 1'b0);
        send_byte(8'hD4, 1'b1);
        wait_done(60);
        check("end_full_word_count", {19'b0, word_count}, 32'd1);

        // Backpressure: output held, lane 3 stalls
        ack_hold = 1'b1;
        exp_q.push_back(32'h01020304);
        exp_q.push_back(32'h05060708);
        start_file();
        for (int i = 1; i <= 7; i++) send_byte(8'(i), 1'b0);
        byte_in = 8'h08;
        byte_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ram_clk);
            check("bp_ready_low", {31'b0, byte_ready}, 32'd0);
            check("bp_bootdata_held", bootdata, 32'h01020304);
        end
        ack_hold = 1'b0;
        send_byte(8'h08, 1'b0);
        end_file();
        wait_done(60);
        check("bp_word_count", {19'b0, word_count}, 32'd2);

        // Loader timing, 16 bytes back-to-back
        ack_delay = 0;
        acks_seen = 0;
        exp_q.push_back(32'h10111213);
        exp_q.push_back(32'h14151617);
        exp_q.push_back(32'h18191A1B);
        exp_q.push_back(32'h1C1D1E1F);
        start_file();
        for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i), 1'b0);
        end_file();
        wait_done(60);
        check("loader_ram_addr", 32'(acks_seen), 32'd4);
        check("loader_word_count", {19'b0, word_count}, 32'd4);

        // Overflow: MAXW words, remaining bytes accepted and discarded
        exp_q.push_back(32'h20212223);
        exp_q.push_back(32'h24252627);
        exp_q.push_back(32'h28292A2B);
        exp_q.push_back(32'h2C2D2E2F);
        start_file();
        for (int i = 0; i < 20; i++) send_byte(8'h20 + 8'(i), 1'b0);
        @(negedge ram_clk);
        check("ovf_ready_high", {31'b0, byte_ready}, 32'd1);
        check("ovf_flag", {31'b0, overflow}, 32'd1);
        repeat (4) tick();
        check("ovf_word_count", {19'b0, word_count}, 32'd4);
        check("ovf_no_extra_req", {31'b0, bootdata_req}, 32'd0);
        start_file();
        @(negedge ram_clk);
        check("abort_overflow_clr", {31'b0, overflow}, 32'd0);
        check("abort_wc_clr", {19'b0, word_count}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd1);
        tick();

        // Abort while a word is pending
        exp_q.push_back(32'h40414243);
        for (int i = 0; i < 4; i++) send_byte(8'h40 + 8'(i), 1'b0);
        repeat (4) tick();
        ack_hold = 1'b1;
        for (int i = 4; i < 8; i++) send_byte(8'h40 + 8'(i), 1'b0);
        @(negedge ram_clk);
        check("pend_req", {31'b0, bootdata_req}, 32'd1);
        check("pend_wc", {19'b0, word_count}, 32'd1);
        tick();
        start_file();
        @(negedge ram_clk);
        check("abort_req_drop", {31'b0, bootdata_req}, 32'd0);
        check("abort_wc_zero", {19'b0, word_count}, 32'd0);
        ack_hold = 1'b0;
        tick();
        end_file();
        wait_done(60);
        check("abort_final_wc", {19'b0, word_count}, 32'd0);

        // Silence after three bytes
        start_file();
`ifdef TAPE_PACKER_TIMEOUT_EN
        exp_q.push_back(32'h11223380);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        wait_done(150);
        check("timeout_busy", {31'b0, busy}, 32'd0);
`else
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        repeat (150) tick();
        check("no_timeout_busy", {31'b0, busy}, 32'd1);
        check("no_timeout_req", {31'b0, bootdata_req}, 32'd0);
        exp_q.push_back(32'h11223380);
        end_file();
        wait_done(60);
`endif
        check("timeout_word_count", {19'b0, word_count}, 32'd1);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
